// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_pkg
// Description : Shared definitions for the push-button conditioner:
//               per-channel state encoding and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package button_conditioner_pkg;

    // Per-channel FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEB_PRESS = 3'd1,
        ST_PRESSED   = 3'd2,
        ST_REPEAT    = 3'd3,
        ST_DEB_REL   = 3'd4
    } btn_state_t;

    // Smallest legal value for any timing parameter
    localparam int c_MIN_PARAM = 2;

    // The counter only ever holds values up to (limit - 1), so
    // $clog2 of the largest limit is enough and it never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_channel
// Description : One button: two-flop synchroniser, counter debouncer and
//               optional auto-repeat.
//   CLK        in  system clock
//   RESET      in  asynchronous active-high reset
//   btn_raw    in  raw, asynchronous button input (1 = pressed)
//   repeat_en  in  auto-repeat enable, sampled every cycle
//   btn_level  out debounced level
//   btn_pulse  out one-cycle pulse per accepted press or repeat
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rdl_last = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_per_last = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]       r_sync;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_pulse_nxt;
    logic             w_s;

    // Synchronised button; the FSM never looks at btn_raw directly
    assign w_s = r_sync[1];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync  <= 2'b00;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;     // pulse is one cycle unless re-armed below
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_DEB_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = ST_PRESSED;
                    w_level_nxt = 1'b1;
                    w_pulse_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_PRESSED: begin
                if (!w_s) begin
                    w_state_nxt = ST_DEB_REL;
                    w_cnt_nxt   = '0;
                end else if (repeat_en && (r_cnt == c_rdl_last)) begin
                    w_state_nxt = ST_REPEAT;
                    w_pulse_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (!repeat_en) begin
                    // Hold the delay counter so enabling repeat restarts the full delay
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_REPEAT: begin
                if (!w_s) begin
                    w_state_nxt = ST_DEB_REL;
                    w_cnt_nxt   = '0;
                end else if (!repeat_en) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_per_last) begin
                    w_pulse_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_DEB_REL: begin
                if (w_s) begin
                    // Release bounce: still pressed, and no new pulse
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = ST_IDLE;
                    w_level_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Input stage for the cursor tracker. Conditions NBTN raw
//               push-buttons (bit 0 right, bit 1 up, bit 2 down) into
//               debounced levels and one-cycle press/repeat pulses.
//   CLK        in  system clock
//   RESET      in  asynchronous active-high reset
//   btn_raw    in  [NBTN] raw bouncing buttons (1 = pressed)
//   repeat_en  in  auto-repeat enable
//   btn_level  out [NBTN] debounced levels
//   btn_pulse  out [NBTN] one-cycle pulses, drive tracker PushButton
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NBTN            = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            repeat_en,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_pulse
);

    generate
        if (NBTN < c_MIN_PARAM || DEBOUNCE_CYCLES < c_MIN_PARAM ||
            REPEAT_DELAY < c_MIN_PARAM || REPEAT_PERIOD < c_MIN_PARAM) begin : g_param_check
            $error("button_conditioner: every parameter must be >= 2");
        end
    endgenerate

    // Channels are independent; simultaneous pulses are resolved downstream
    generate
        for (genvar i = 0; i < NBTN; i++) begin : g_chan
            button_conditioner_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .CLK       (CLK),
                .RESET     (RESET),
                .btn_raw   (btn_raw[i]),
                .repeat_en (repeat_en),
                .btn_level (btn_level[i]),
                .btn_pulse (btn_pulse[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed, table-driven bench for button_conditioner with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
//               Vector n drives inputs sampled at edge n; outputs are
//               checked 1 time unit after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int NBTN = 3;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [NBTN-1:0] btn_raw;
    logic            repeat_en;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0] raw;
        logic       rep;
        logic [2:0] level;
        logic [2:0] pulse;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .NBTN            (NBTN),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int cyc,
                         input logic [2:0] lvl, input logic [2:0] pls);
        tests_run++;
        if (btn_level !== lvl || btn_pulse !== pls) begin
            tests_failed++;
            $display("FAIL %s edge %0d: level=%b pulse=%b, expected level=%b pulse=%b",
                     name, cyc, btn_level, btn_pulse, lvl, pls);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        btn_raw   = '0;
        repeat_en = 1'b0;
        RESET     = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("reset", 0, 3'b000, 3'b000);
    endtask

    function automatic void push(input logic [2:0] raw, input logic rep,
                                 input logic [2:0] lvl, input logic [2:0] pls);
        vec_t v;
        v.raw   = raw;
        v.rep   = rep;
        v.level = lvl;
        v.pulse = pls;
        vecs.push_back(v);
    endfunction

    task automatic run_vectors(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw   = vecs[i].raw;
            repeat_en = vecs[i].rep;
            tick();
            check(name, i + 1, vecs[i].level, vecs[i].pulse);
        end
        vecs.delete();
    endtask

    initial begin
        RESET     = 1'b1;
        btn_raw   = '0;
        repeat_en = 1'b0;

        // 1. Clean press: raw[0] high edges 1..8; pulse at 7, release falls at 15
        do_reset();
        for (int c = 1; c <= 18; c++)
            push((c <= 8) ? 3'b001 : 3'b000, 1'b0,
                 (c >= 7 && c <= 14) ? 3'b001 : 3'b000,
                 (c == 7) ? 3'b001 : 3'b000);
        run_vectors("clean_press");

        // 2. Bounce: raw[1] = 1,0,1,0 then stays 1 from edge 5; one pulse at 11
        do_reset();
        for (int c = 1; c <= 15; c++)
            push((c == 2 || c == 4) ? 3'b000 : 3'b010, 1'b0,
                 (c >= 11) ? 3'b010 : 3'b000,
                 (c == 11) ? 3'b010 : 3'b000);
        run_vectors("bounce");

        // 3a. Auto-repeat: raw[2] held edges 1..30; pulses 7, 17, 20, ... 32
        do_reset();
        for (int c = 1; c <= 40; c++)
            push((c <= 30) ? 3'b100 : 3'b000, 1'b1,
                 (c >= 7 && c <= 36) ? 3'b100 : 3'b000,
                 (c == 7 || (c >= 17 && c <= 32 && ((c - 17) % 3) == 0)) ? 3'b100 : 3'b000);
        run_vectors("repeat_on");

        // 3b. Same stimulus, repeat disabled: single pulse at 7
        do_reset();
        for (int c = 1; c <= 40; c++)
            push((c <= 30) ? 3'b100 : 3'b000, 1'b0,
                 (c >= 7 && c <= 36) ? 3'b100 : 3'b000,
                 (c == 7) ? 3'b100 : 3'b000);
        run_vectors("repeat_off");

        // 4. Release bounce: raw[0] drops at edges 13,14 then returns; final release edge 21
        do_reset();
        for (int c = 1; c <= 30; c++)
            push((c <= 12 || (c >= 15 && c <= 20)) ? 3'b001 : 3'b000, 1'b0,
                 (c >= 7 && c <= 26) ? 3'b001 : 3'b000,
                 (c == 7) ? 3'b001 : 3'b000);
        run_vectors("release_bounce");

        // 6. Simultaneous press of buttons 0 and 1
        do_reset();
        for (int c = 1; c <= 10; c++)
            push(3'b011, 1'b0,
                 (c >= 7) ? 3'b011 : 3'b000,
                 (c == 7) ? 3'b011 : 3'b000);
        run_vectors("simultaneous");

        // 5. Asynchronous reset while in REPEAT, button still held afterwards
        do_reset();
        repeat_en = 1'b1;
        btn_raw   = 3'b010;
        for (int c = 1; c <= 17; c++) tick();
        check("rst_pre", 17, 3'b010, 3'b010);
        #2;
        RESET = 1'b1;
        #1;
        check("rst_async", 17, 3'b000, 3'b000);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check("rst_repress", c,
                  (c >= 7) ? 3'b010 : 3'b000,
                  (c == 7) ? 3'b010 : 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
